// File: rtl/event_counter_bank_if.sv
// Control and read-port bundle for event_counter_bank.
// The master drives strobes and read requests; the slave (the counter bank) returns data and flags.
interface event_counter_bank_if #(
  parameter int unsigned WIDTH     = 64,
  parameter int unsigned CHANNELS  = 4,
  parameter int unsigned SEL_WIDTH = 2
) ();
  logic                 en;
  logic [CHANNELS-1:0]  inc;
  logic [CHANNELS-1:0]  clear;
  logic                 freeze;
  logic                 rd_req;
  logic [SEL_WIDTH-1:0] rd_sel;
  logic [WIDTH-1:0]     rd_data;
  logic                 rd_valid;
  logic                 rd_err;
  logic [CHANNELS-1:0]  ovf;

  modport master (
    output en, inc, clear, freeze, rd_req, rd_sel,
    input  rd_data, rd_valid, rd_err, ovf
  );

  modport slave (
    input  en, inc, clear, freeze, rd_req, rd_sel,
    output rd_data, rd_valid, rd_err, ovf
  );
endinterface

// File: rtl/event_counter_bank.sv
// Multi-channel event counter bank with sticky overflow, global freeze snapshot
// and a fixed one-cycle-latency snapshot read port.
module event_counter_bank #(
  parameter int unsigned WIDTH     = 64,
  parameter int unsigned CHANNELS  = 4,
  parameter int unsigned SEL_WIDTH = 2,
  parameter bit          SATURATE  = 1'b0
) (
  input logic           i_clk,
  input logic           i_rst,
  event_counter_bank_if.slave bus
);

  localparam logic [WIDTH-1:0] MaxCount = {WIDTH{1'b1}};

  logic [WIDTH-1:0]    r_count [CHANNELS];
  logic [WIDTH-1:0]    r_snap  [CHANNELS];
  logic [CHANNELS-1:0] r_ovf;
  logic [WIDTH-1:0]    r_rd_data;
  logic                r_rd_valid;
  logic                r_rd_err;

  logic [WIDTH-1:0]    w_sel_snap;
  logic                w_sel_ok;

  // Decode by matching each channel index, so out-of-range selects fall through to zero.
  always_comb begin
    w_sel_snap = '0;
    w_sel_ok   = 1'b0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (bus.rd_sel == SEL_WIDTH'(i)) begin
        w_sel_snap = r_snap[i];
        w_sel_ok   = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        r_count[i] <= '0;
        r_snap[i]  <= '0;
      end
      r_ovf      <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_rd_err   <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        if (bus.clear[i]) begin
          r_count[i] <= '0;
          r_ovf[i]   <= 1'b0;
        end else if (bus.en && bus.inc[i]) begin
          if (r_count[i] == MaxCount) begin
            r_ovf[i] <= 1'b1;
            if (!SATURATE) r_count[i] <= '0;
          end else begin
            r_count[i] <= r_count[i] + WIDTH'(1);
          end
        end
        // Non-blocking capture takes the pre-edge count, ahead of any clear or increment.
        if (bus.freeze) r_snap[i] <= r_count[i];
      end

      // Read uses the pre-edge snapshot, so a same-cycle freeze is not visible.
      r_rd_valid <= bus.rd_req;
      r_rd_err   <= bus.rd_req && !w_sel_ok;
      if (bus.rd_req) r_rd_data <= w_sel_snap;
    end
  end

  assign bus.rd_data  = r_rd_data;
  assign bus.rd_valid = r_rd_valid;
  assign bus.rd_err   = r_rd_err;
  assign bus.ovf      = r_ovf;

endmodule

// File: tb/tb_event_counter_bank.sv
// Directed bench: two 8-bit, 4-channel banks (wrap and saturate) driven in lockstep,
// plus a 3-channel bank for out-of-range and back-to-back read cases.
module tb_event_counter_bank;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  event_counter_bank_if #(.WIDTH(8), .CHANNELS(4), .SEL_WIDTH(2)) a_if ();
  event_counter_bank_if #(.WIDTH(8), .CHANNELS(4), .SEL_WIDTH(2)) b_if ();
  event_counter_bank_if #(.WIDTH(8), .CHANNELS(3), .SEL_WIDTH(2)) c_if ();

  event_counter_bank #(.WIDTH(8), .CHANNELS(4), .SEL_WIDTH(2), .SATURATE(1'b0)) u_wrap (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (a_if)
  );

  event_counter_bank #(.WIDTH(8), .CHANNELS(4), .SEL_WIDTH(2), .SATURATE(1'b1)) u_sat (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (b_if)
  );

  event_counter_bank #(.WIDTH(8), .CHANNELS(3), .SEL_WIDTH(2), .SATURATE(1'b0)) u_ch3 (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (c_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv_ab(input logic en, input logic [3:0] inc, input logic [3:0] clr,
                        input logic frz);
    a_if.en = en;  a_if.inc = inc;  a_if.clear = clr;  a_if.freeze = frz;
    b_if.en = en;  b_if.inc = inc;  b_if.clear = clr;  b_if.freeze = frz;
  endtask

  task automatic run_ab(input logic [3:0] inc, input int n);
    drv_ab(1'b1, inc, 4'b0000, 1'b0);
    for (int k = 0; k < n; k++) step();
    drv_ab(1'b0, 4'b0000, 4'b0000, 1'b0);
  endtask

  task automatic freeze_ab();
    drv_ab(1'b0, 4'b0000, 4'b0000, 1'b1);
    step();
    drv_ab(1'b0, 4'b0000, 4'b0000, 1'b0);
  endtask

  task automatic read_ab(input logic [1:0] sel, input logic [7:0] ea, input logic [7:0] eb,
                         input string tag);
    a_if.rd_req = 1'b1;  a_if.rd_sel = sel;
    b_if.rd_req = 1'b1;  b_if.rd_sel = sel;
    step();
    a_if.rd_req = 1'b0;
    b_if.rd_req = 1'b0;
    check({tag, " wrap valid"}, 64'(a_if.rd_valid), 64'd1);
    check({tag, " wrap data"}, 64'(a_if.rd_data), 64'(ea));
    check({tag, " sat data"}, 64'(b_if.rd_data), 64'(eb));
  endtask

  task automatic read_c(input logic [1:0] sel);
    c_if.rd_req = 1'b1;
    c_if.rd_sel = sel;
    step();
    c_if.rd_req = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    drv_ab(1'b0, 4'b0000, 4'b0000, 1'b0);
    a_if.rd_req = 1'b0;  a_if.rd_sel = 2'd0;
    b_if.rd_req = 1'b0;  b_if.rd_sel = 2'd0;
    c_if.en = 1'b0;  c_if.inc = 3'b000;  c_if.clear = 3'b000;  c_if.freeze = 1'b0;
    c_if.rd_req = 1'b0;  c_if.rd_sel = 2'd0;

    // Reset and idle with enable low
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    check("reset ovf", 64'(a_if.ovf), 64'd0);
    check("reset rd_valid", 64'(a_if.rd_valid), 64'd0);
    check("reset rd_data", 64'(a_if.rd_data), 64'd0);
    drv_ab(1'b0, 4'hF, 4'b0000, 1'b0);
    for (int k = 0; k < 10; k++) step();
    drv_ab(1'b0, 4'b0000, 4'b0000, 1'b0);
    check("idle ovf", 64'(a_if.ovf), 64'd0);
    check("idle rd_valid", 64'(a_if.rd_valid), 64'd0);
    freeze_ab();
    for (int ch = 0; ch < 4; ch++) read_ab(2'(ch), 8'd0, 8'd0, "idle read");
    step();
    check("valid is a pulse", 64'(a_if.rd_valid), 64'd0);

    // Independent counting on channels 0 and 2
    run_ab(4'b0101, 5);
    freeze_ab();
    read_ab(2'd0, 8'd5, 8'd5, "count ch0");
    read_ab(2'd1, 8'd0, 8'd0, "count ch1");
    read_ab(2'd2, 8'd5, 8'd5, "count ch2");
    read_ab(2'd3, 8'd0, 8'd0, "count ch3");
    check("count ovf", 64'(a_if.ovf), 64'd0);

    // Wrap vs saturate on channel 0 across the max boundary
    drv_ab(1'b0, 4'b0000, 4'hF, 1'b0);
    step();
    run_ab(4'b0001, 255);
    check("at max wrap ovf", 64'(a_if.ovf), 64'd0);
    check("at max sat ovf", 64'(b_if.ovf), 64'd0);
    run_ab(4'b0001, 2);
    check("past max wrap ovf", 64'(a_if.ovf), 64'b0001);
    check("past max sat ovf", 64'(b_if.ovf), 64'b0001);
    freeze_ab();
    read_ab(2'd0, 8'd1, 8'd255, "257 incs");
    run_ab(4'b0001, 3);
    check("ovf sticky", 64'(a_if.ovf), 64'b0001);
    drv_ab(1'b0, 4'b0000, 4'b0001, 1'b0);
    step();
    drv_ab(1'b0, 4'b0000, 4'b0000, 1'b0);
    check("clear wrap ovf", 64'(a_if.ovf), 64'd0);
    check("clear sat ovf", 64'(b_if.ovf), 64'd0);
    freeze_ab();
    read_ab(2'd0, 8'd0, 8'd0, "after clear");

    // Clear + increment + freeze together on channel 1
    run_ab(4'b0010, 7);
    drv_ab(1'b1, 4'b0010, 4'b0010, 1'b1);
    step();
    drv_ab(1'b0, 4'b0000, 4'b0000, 1'b0);
    read_ab(2'd1, 8'd7, 8'd7, "prio snap");
    freeze_ab();
    read_ab(2'd1, 8'd0, 8'd0, "prio live");
    run_ab(4'b0010, 1);
    freeze_ab();
    read_ab(2'd1, 8'd1, 8'd1, "prio resume");

    // Read and freeze in the same cycle return the old snapshot
    run_ab(4'b0010, 1);
    drv_ab(1'b0, 4'b0000, 4'b0000, 1'b1);
    read_ab(2'd1, 8'd1, 8'd1, "read+freeze");
    drv_ab(1'b0, 4'b0000, 4'b0000, 1'b0);
    read_ab(2'd1, 8'd2, 8'd2, "after freeze");

    // Mid-operation reset with a read in flight
    run_ab(4'b1000, 256);
    check("ch3 wrap ovf", 64'(a_if.ovf), 64'b1000);
    check("ch3 sat ovf", 64'(b_if.ovf), 64'b1000);
    rst = 1'b1;
    a_if.rd_req = 1'b1;  a_if.rd_sel = 2'd1;
    b_if.rd_req = 1'b1;  b_if.rd_sel = 2'd1;
    step();
    rst = 1'b0;
    a_if.rd_req = 1'b0;
    b_if.rd_req = 1'b0;
    check("rst rd_valid", 64'(a_if.rd_valid), 64'd0);
    check("rst rd_data", 64'(a_if.rd_data), 64'd0);
    check("rst rd_err", 64'(a_if.rd_err), 64'd0);
    check("rst wrap ovf", 64'(a_if.ovf), 64'd0);
    check("rst sat ovf", 64'(b_if.ovf), 64'd0);
    check("rst sat rd_data", 64'(b_if.rd_data), 64'd0);
    run_ab(4'b0001, 1);
    freeze_ab();
    read_ab(2'd0, 8'd1, 8'd1, "post-rst ch0");
    read_ab(2'd3, 8'd0, 8'd0, "post-rst ch3");

    // Three-channel bank: back-to-back reads, out-of-range select
    c_if.en = 1'b1;
    c_if.inc = 3'b111;
    step();
    step();
    c_if.inc = 3'b010;
    step();
    c_if.inc = 3'b100;
    step();
    step();
    step();
    c_if.inc = 3'b000;
    c_if.freeze = 1'b1;
    step();
    c_if.freeze = 1'b0;
    c_if.rd_req = 1'b1;
    c_if.rd_sel = 2'd0;
    step();
    check("b2b sel0 valid", 64'(c_if.rd_valid), 64'd1);
    check("b2b sel0 data", 64'(c_if.rd_data), 64'd2);
    c_if.rd_sel = 2'd1;
    step();
    check("b2b sel1 valid", 64'(c_if.rd_valid), 64'd1);
    check("b2b sel1 data", 64'(c_if.rd_data), 64'd3);
    c_if.rd_sel = 2'd2;
    step();
    c_if.rd_req = 1'b0;
    check("b2b sel2 valid", 64'(c_if.rd_valid), 64'd1);
    check("b2b sel2 data", 64'(c_if.rd_data), 64'd5);
    check("b2b sel2 err", 64'(c_if.rd_err), 64'd0);
    step();
    check("b2b idle valid", 64'(c_if.rd_valid), 64'd0);
    check("rd_data holds", 64'(c_if.rd_data), 64'd5);
    read_c(2'd3);
    check("oor valid", 64'(c_if.rd_valid), 64'd1);
    check("oor err", 64'(c_if.rd_err), 64'd1);
    check("oor data", 64'(c_if.rd_data), 64'd0);
    step();
    check("err is a pulse", 64'(c_if.rd_err), 64'd0);

    c_if.inc = 3'b001;
    step();
    c_if.inc = 3'b000;
    c_if.freeze = 1'b1;
    read_c(2'd0);
    c_if.freeze = 1'b0;
    check("c read+freeze", 64'(c_if.rd_data), 64'd2);
    read_c(2'd0);
    check("c after freeze", 64'(c_if.rd_data), 64'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
